// File: rtl/seq_div32.sv
// seq_div32: multi-cycle radix-2 restoring divider, WIDTH+1 edges per result.
// Define SEQ_DIV32_SIGNED_EN for two's-complement operands; default build is unsigned.
module seq_div32 #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             out_valid,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   acc_q, acc_d, sh_w;
  logic [WIDTH+1:0] diff_w;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, mag_a, mag_b, quot_d, rem_d, quot_q, rem_q;
  logic             neg_quot_q, neg_rem_q, zero_q, valid_q, dz_q, sign_a, sign_b;
`ifdef SEQ_DIV32_SIGNED_EN
  assign sign_a = in_a[WIDTH-1];
  assign sign_b = in_b[WIDTH-1];
`else
  assign sign_a = 1'b0;
  assign sign_b = 1'b0;
`endif
  // acc holds the WIDTH+1 bit partial remainder; dvd shifts the dividend out and quotient bits in
  always_comb begin
    mag_a  = sign_a ? -in_a : in_a;
    mag_b  = sign_b ? -in_b : in_b;
    sh_w   = {acc_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    diff_w = {1'b0, sh_w} - {2'b00, dvs_q};
    acc_d  = diff_w[WIDTH+1] ? sh_w : diff_w[WIDTH:0];
    dvd_d  = {dvd_q[WIDTH-2:0], ~diff_w[WIDTH+1]};
    quot_d = zero_q ? '1 : neg_quot_q ? -dvd_q : dvd_q;
    rem_d  = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  end
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      valid_q    <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      case (state_q)
        CALC: begin
          if (cnt_q == CW'(WIDTH)) begin
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            valid_q <= 1'b1;
            dz_q    <= zero_q;
            state_q <= DONE;
          end else begin
            acc_q <= acc_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (start) begin
            dvd_q      <= mag_a;
            dvs_q      <= mag_b;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_quot_q <= sign_a ^ sign_b;
            neg_rem_q  <= sign_a;
            zero_q     <= (in_b == '0);
            valid_q    <= 1'b0;
            dz_q       <= 1'b0;
            state_q    <= CALC;
          end
        end
      endcase
    end
  end
  assign busy      = (state_q == CALC);
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign out_valid = valid_q;
  assign div_zero  = dz_q;
endmodule

// File: doc/seq_div32.md
SEQ_DIV32 -- requirements
Module: seq_div32

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand, quotient and remainder width in bits.
REQ-002 The module SHALL have port CLK  input  1  clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 The module SHALL have port start  input  1  request to begin a division; sampled on the rising edge of CLK.
REQ-005 The module SHALL have port in_a  input  WIDTH  dividend; sampled on the edge that accepts start.
REQ-006 The module SHALL have port in_b  input  WIDTH  divisor; sampled on the edge that accepts start.
REQ-007 The module SHALL have port busy  output  1  high while in the CALC state.
REQ-008 The module SHALL have port quot  output  WIDTH  registered quotient.
REQ-009 The module SHALL have port rem  output  WIDTH  registered remainder.
REQ-010 The module SHALL have port out_valid  output  1  high while quot and rem hold a completed result.
REQ-011 The module SHALL have port div_zero  output  1  high together with out_valid when the accepted divisor was 0.

Function
REQ-012 The module SHALL implement the states IDLE, CALC and DONE.
REQ-013 In IDLE or DONE, start=1 at a rising edge SHALL capture in_a and in_b, clear out_valid and div_zero, load the iteration counter with 0, and move to CALC.
REQ-014 start SHALL be ignored while in CALC; the captured operands SHALL NOT change until the next accepted start.
REQ-015 CALC SHALL perform one radix-2 restoring iteration per cycle on the operand magnitudes: shift the partial remainder left by one bit, trial-subtract the divisor, and keep the difference and set the quotient bit only if the difference is non-negative.
REQ-016 After WIDTH iterations, the next edge SHALL apply sign correction, register quot and rem, set out_valid to 1, and move to DONE.
REQ-017 Latency SHALL be WIDTH+1 rising edges from the accepting edge to the edge that sets out_valid (33 for WIDTH=32).
REQ-018 The partial-remainder datapath SHALL be WIDTH+1 bits wide so that trial subtraction never overflows.
REQ-019 out_valid, quot, rem and div_zero SHALL hold their values in DONE until the next accepted start or reset.
REQ-020 A divisor of 0 SHALL take the full latency and then produce quot equal to all ones, rem equal to the dividend, and div_zero=1.
REQ-021 Signed quotient rounding SHALL truncate toward zero, and rem SHALL take the sign of the dividend, so that quot*in_b+rem equals in_a.
REQ-022 In signed mode, -2^(WIDTH-1) / -1 SHALL yield quot = -2^(WIDTH-1) (wrap-around) and rem = 0, with no error flag.
REQ-023 start=1 on the same edge that sets out_valid SHALL be ignored, because the block is still in CALC at that edge.

Reset
REQ-024 While reset is high, the state SHALL be IDLE, busy=0, out_valid=0, div_zero=0, quot=0, rem=0, and the counter and internal registers SHALL be 0.
REQ-025 Reset asserted during CALC SHALL abort the division, produce no result, and leave the block idle until the next accepted start after reset is released.

Configuration
REQ-026 With macro SEQ_DIV32_SIGNED_EN defined, operands SHALL be two's-complement: magnitudes are taken at capture and the quotient is negated when the operand signs differ, per REQ-021 and REQ-022.
REQ-027 Without SEQ_DIV32_SIGNED_EN, operands and results SHALL be unsigned, no sign correction SHALL be applied, and REQ-022 SHALL NOT apply; latency SHALL be unchanged.

Verification
REQ-028 Basic division: start with a=90, b=30 -> after 33 edges out_valid=1, quot=3, rem=0, div_zero=0.
REQ-029 Signed operands (signed build): a=100, b=-7 -> quot=-14, rem=2; a=-100, b=7 -> quot=-14, rem=-2; a=-90, b=-30 -> quot=3, rem=0.
REQ-030 Divide by zero: a=1234, b=0 -> quot=0xFFFFFFFF, rem=1234, div_zero=1 after 33 edges.
REQ-031 Overflow case (signed build): a=0x80000000, b=0xFFFFFFFF -> quot=0x80000000, rem=0; unsigned build with the same operands -> quot=0, rem=0x80000000.
REQ-032 Start during busy and reset mid-operation: start pulses during CALC leave the result unchanged; reset at cycle 10 of CALC -> outputs 0 and out_valid=0, and a following start of 7/2 -> quot=3, rem=1.
REQ-033 Back-to-back operations: start asserted in DONE -> out_valid drops on the accepting edge and the new result appears 33 edges later.
